pokey_keyboard_scanner: RTL and testbench

POKEY-side keyboard scan engine: drives the active-low 6-bit scan address onto `key_scan_L`, samples the controller's `kr1_L`/`kr2_L` returns, debounces, and latches a key code with a one-cycle interrupt pulse. It sits inside POKEY facing the controller interface block. It owns the scan counter, the compare register and the debounce FSM. The KBCODE/SKSTAT/IRQ register logic consumes its outputs.

---
 rtl/pokey_keyboard_scanner_pkg.sv | 7 +
 rtl/pokey_keyboard_scanner_if.sv | 14 +
 rtl/pokey_scan_timer.sv | 31 +++
 rtl/pokey_keyboard_scanner.sv | 83 ++++++++
 tb/tb_pokey_keyboard_scanner.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/pokey_keyboard_scanner_pkg.sv
// pokey_pkg: shared types and sizes for the POKEY keyboard scan engine
package pokey_pkg;
  localparam int SCAN_STEPS = 64;
  localparam int SCAN_W = 6;
  localparam int KBCODE_W = 7;
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD} kbd_state_t;
endpackage

// File: rtl/pokey_keyboard_scanner_if.sv
// pokey_keyboard_scanner_if: SKCTL controls, controller returns and key outputs
interface pokey_keyboard_scanner_if;
  import pokey_pkg::*;
  logic scan_en;
  logic debounce_en;
  logic kr1_L;
  logic kr2_L;
  logic [SCAN_W-1:0] key_scan_L;
  logic [KBCODE_W-1:0] kbcode;
  logic key_down;
  logic key_irq;
  modport master (output scan_en, debounce_en, kr1_L, kr2_L, input key_scan_L, kbcode, key_down, key_irq);
  modport slave (input scan_en, debounce_en, kr1_L, kr2_L, output key_scan_L, kbcode, key_down, key_irq);
endinterface

// File: rtl/pokey_scan_timer.sv
// pokey_scan_timer: scan step divider and 6-bit scan address counter
module pokey_scan_timer
  import pokey_pkg::*;
#(
  parameter int SCAN_DIV = 114
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              en_i,
  output logic              tc_o,
  output logic [SCAN_W-1:0] scan_cnt_o
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [DW-1:0] div_q, div_d;
  logic [$clog2(SCAN_STEPS)-1:0] scan_q, scan_d;
  assign tc_o = en_i && div_q == DW'(SCAN_DIV - 1);
  assign scan_cnt_o = scan_q;
  always_comb begin
    div_d = !en_i || tc_o ? '0 : div_q + 1'b1;
    scan_d = !en_i ? '0 : tc_o ? scan_q + 1'b1 : scan_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      div_q <= '0;
      scan_q <= '0;
    end else begin
      div_q <= div_d;
      scan_q <= scan_d;
    end
  end
endmodule

// File: rtl/pokey_keyboard_scanner.sv
// pokey_keyboard_scanner: keyboard scan, two-scan debounce FSM and key code latch
module pokey_keyboard_scanner
  import pokey_pkg::*;
#(
  parameter int SCAN_DIV = 114
) (
  input logic clk,
  input logic rst_L,
  pokey_keyboard_scanner_if.slave bus
);
  logic tc;
  logic latch;
  logic [SCAN_W-1:0] scan_cnt;
  kbd_state_t state_q, state_d;
  logic [SCAN_W-1:0] cmp_q, cmp_d;
  logic [KBCODE_W-1:0] kbcode_q, kbcode_d;
  logic down_q, down_d, irq_q, irq_d;
  pokey_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk(clk),
    .rst_L(rst_L),
    .en_i(bus.scan_en),
    .tc_o(tc),
    .scan_cnt_o(scan_cnt)
  );
  assign bus.key_scan_L = ~scan_cnt;
  assign bus.kbcode = kbcode_q;
  assign bus.key_down = down_q;
  assign bus.key_irq = irq_q;
  // Once a candidate is chosen, only its own address is looked at until IDLE
  always_comb begin
    state_d = state_q;
    cmp_d = cmp_q;
    kbcode_d = kbcode_q;
    down_d = down_q;
    irq_d = 1'b0;
    latch = 1'b0;
    if (!bus.scan_en) begin
      state_d = IDLE;
      cmp_d = '0;
      down_d = 1'b0;
    end else if (tc) begin
      case (state_q)
        IDLE: if (!bus.kr1_L) begin
          if (bus.debounce_en) begin
            cmp_d = scan_cnt;
            state_d = CONFIRM;
          end else latch = 1'b1;
        end
        CONFIRM: if (scan_cnt == cmp_q) begin
          if (bus.kr1_L) state_d = IDLE;
          else latch = 1'b1;
        end
        HELD: if (scan_cnt == cmp_q && bus.kr1_L) begin
          down_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (latch) begin
      kbcode_d = {~bus.kr2_L, scan_cnt};
      cmp_d = scan_cnt;
      down_d = 1'b1;
      irq_d = 1'b1;
      state_d = HELD;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q <= IDLE;
      cmp_q <= '0;
      kbcode_q <= '0;
      down_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmp_q <= cmp_d;
      kbcode_q <= kbcode_d;
      down_q <= down_d;
      irq_q <= irq_d;
    end
  end
endmodule

// File: tb/tb_pokey_keyboard_scanner.sv
// tb_pokey_keyboard_scanner: keyboard matrix model with an IRQ scoreboard
module tb_pokey_keyboard_scanner;
  import pokey_pkg::*;
  typedef struct {
    logic [6:0] code;
    int t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic [63:0] mask = '0;
  logic kr2 = 1'b1;
  logic [5:0] addr;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  exp_t e;
  pokey_keyboard_scanner_if bus ();
  pokey_keyboard_scanner #(.SCAN_DIV(4)) dut (
    .clk(clk),
    .rst_L(rst_L),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Matrix model: a pressed key pulls kr1_L low while its address is driven
  assign addr = ~bus.key_scan_L;
  assign bus.kr1_L = ~mask[addr];
  assign bus.kr2_L = kr2;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic arm(input logic [5:0] a, input logic [63:0] m, output int t);
    int n = 0;
    while (addr == a && n < 8) begin
      @(negedge clk);
      n++;
    end
    mask = m;
    while (addr != a && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("arm_reach", int'(addr == a), 1);
    t = cyc;
  endtask
  always @(negedge clk) begin
    if (rst_L && bus.key_irq) begin
      if (sb.size() == 0) chk("spurious_irq", 1, 0);
      else begin
        e = sb.pop_front();
        chk("irq_code", int'(bus.kbcode), int'(e.code));
        chk("irq_cycle", cyc, e.t);
      end
    end
  end
  initial begin
    int t, n;
    logic [5:0] prev, want;
    bus.scan_en = 1'b1;
    bus.debounce_en = 1'b1;
    cycles(3);
    chk("rst_scan", int'(bus.key_scan_L), 'h3f);
    chk("rst_kbcode", int'(bus.kbcode), 0);
    chk("rst_down", int'(bus.key_down), 0);
    chk("rst_irq", int'(bus.key_irq), 0);
    rst_L = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      prev = bus.key_scan_L;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.key_scan_L == prev && n < 10);
      want = ~6'(i);
      chk("scan_val", int'(bus.key_scan_L), int'(want));
      chk("scan_period", n, 4);
    end
    arm(6'h12, 64'd1 << 6'h12, t);
    sb.push_back('{7'h12, t + 260});
    cycles(270);
    chk("deb_irq_seen", sb.size(), 0);
    chk("deb_down", int'(bus.key_down), 1);
    chk("deb_kbcode", int'(bus.kbcode), 'h12);
    mask = '0;
    cycles(300);
    chk("deb_release", int'(bus.key_down), 0);
    arm(6'h12, 64'd1 << 6'h12, t);
    sb.push_back('{7'h52, t + 260});
    cycles(20);
    kr2 = 1'b0;
    cycles(250);
    chk("shift_irq_seen", sb.size(), 0);
    chk("shift_kbcode", int'(bus.kbcode), 'h52);
    mask = '0;
    kr2 = 1'b1;
    cycles(300);
    chk("shift_release", int'(bus.key_down), 0);
    arm(6'h12, 64'd1 << 6'h12, t);
    n = 0;
    while (addr == 6'h12 && n < 8) begin
      @(negedge clk);
      n++;
    end
    mask = '0;
    cycles(300);
    chk("bounce_kbcode", int'(bus.kbcode), 'h52);
    chk("bounce_down", int'(bus.key_down), 0);
    arm(6'h12, 64'd1 << 6'h12, t);
    sb.push_back('{7'h12, t + 260});
    cycles(5 * 256);
    chk("held_down", int'(bus.key_down), 1);
    chk("held_one_irq", sb.size(), 0);
    mask = '0;
    n = 0;
    while (bus.key_down && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("held_release", int'(bus.key_down), 0);
    arm(6'h12, 64'd1 << 6'h12, t);
    cycles(50);
    rst_L = 1'b0;
    mask = '0;
    @(negedge clk);
    chk("midrst_kbcode", int'(bus.kbcode), 0);
    chk("midrst_down", int'(bus.key_down), 0);
    chk("midrst_scan", int'(bus.key_scan_L), 'h3f);
    chk("midrst_irq", int'(bus.key_irq), 0);
    bus.debounce_en = 1'b0;
    rst_L = 1'b1;
    arm(6'h05, (64'd1 << 6'h05) | (64'd1 << 6'h20), t);
    sb.push_back('{7'h05, t + 4});
    cycles(600);
    chk("multi_irq_seen", sb.size(), 0);
    chk("multi_kbcode", int'(bus.kbcode), 'h05);
    chk("multi_down", int'(bus.key_down), 1);
    bus.scan_en = 1'b0;
    cycles(2);
    chk("dis_scan", int'(bus.key_scan_L), 'h3f);
    chk("dis_down", int'(bus.key_down), 0);
    chk("dis_kbcode", int'(bus.kbcode), 'h05);
    chk("dis_irq", int'(bus.key_irq), 0);
    cycles(20);
    chk("dis_end_sb", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
